// File: rtl/quad_or_self_test_ctrl.sv
// ---------------------------------------------------------------------------
// quad_or_self_test_ctrl
//
// Built-in self-test sequencer for one quad 2-input OR gate package. Drives
// all four channels through every {a,b} combination, waits a settle window
// after each vector, compares every Y output against a|b and reports sticky
// per-channel faults behind a start/busy/done handshake.
//
// Channel k is fed v = (vec_idx + k) mod 4 with {a,b} = v, so neighbouring
// channels never carry identical inputs and shorted outputs show up.
//
// Parameters:
//   SETTLE_CYCLES  cycles spent in SETTLE after each vector (0..255)
//   LOOPS          full 4-vector passes per run (1..15)
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset
//   start      run request, sampled only in IDLE
//   busy       high while a run is in progress
//   done       one-cycle pulse at the end of a run
//   pass       result of the last run (1 = no channel failed)
//   a_out      channel a inputs to the gate (bit k = channel k+1)
//   b_out      channel b inputs to the gate
//   y_in       gate outputs Y1..Y4 (bit k = Y(k+1))
//   fail_mask  sticky per-channel mismatch flags
//   vec_idx    current vector index (debug)
//   fail_vec   vector index of the first failing CHECK
//              (only when QUAD_OR_ABORT_ON_FAIL_EN is defined)
//
// Optional feature macro: QUAD_OR_ABORT_ON_FAIL_EN
//   defined   -> the first failing CHECK ends the run immediately and its
//                vector index is captured on fail_vec
//   undefined -> every run covers all LOOPS*4 vectors
// ---------------------------------------------------------------------------
module quad_or_self_test_ctrl #(
   parameter int SETTLE_CYCLES = 2,
   parameter int LOOPS         = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] a_out,
   output logic [3:0] b_out,
   input  logic [3:0] y_in,
   output logic [3:0] fail_mask,
`ifdef QUAD_OR_ABORT_ON_FAIL_EN
   output logic [1:0] fail_vec,
`endif
   output logic [1:0] vec_idx
);

   localparam logic [7:0] SETTLE_INIT = 8'(SETTLE_CYCLES);
   localparam logic [3:0] LOOP_LAST   = 4'(LOOPS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_APPLY,
      S_SETTLE,
      S_CHECK,
      S_DONE
   } state_t;

   state_t     state;
   logic [7:0] settle_cnt;
   logic [3:0] loop_cnt;

   // Index of the vector about to be applied. The outputs are loaded on the
   // edge that enters APPLY so they are stable across APPLY..CHECK.
   logic [1:0] next_idx;
   logic [3:0] a_map;
   logic [3:0] b_map;
   logic [3:0] mism;
   logic [3:0] mask_upd;

   always_comb begin
      next_idx = 2'd0;
      if (state == S_CHECK) begin
         next_idx = vec_idx + 2'd1;   // wraps 3 -> 0 for the next loop
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_ch
         logic [1:0] v;
         assign v         = next_idx + 2'(gi);
         assign a_map[gi] = v[1];
         assign b_map[gi] = v[0];
         // Compare against the inputs currently driven to this channel.
         assign mism[gi]  = y_in[gi] ^ (a_out[gi] | b_out[gi]);
      end
   endgenerate

   assign mask_upd = fail_mask | mism;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         a_out      <= 4'd0;
         b_out      <= 4'd0;
         fail_mask  <= 4'd0;
         vec_idx    <= 2'd0;
         loop_cnt   <= 4'd0;
         settle_cnt <= 8'd0;
`ifdef QUAD_OR_ABORT_ON_FAIL_EN
         fail_vec   <= 2'd0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  fail_mask <= 4'd0;
                  pass      <= 1'b0;
                  vec_idx   <= 2'd0;
                  loop_cnt  <= 4'd0;
                  busy      <= 1'b1;
                  a_out     <= a_map;
                  b_out     <= b_map;
`ifdef QUAD_OR_ABORT_ON_FAIL_EN
                  fail_vec  <= 2'd0;
`endif
                  state     <= S_APPLY;
               end
            end

            S_APPLY: begin
               settle_cnt <= SETTLE_INIT;
               if (SETTLE_INIT != 8'd0) begin
                  state <= S_SETTLE;
               end else begin
                  state <= S_CHECK;
               end
            end

            S_SETTLE: begin
               // Counter was loaded with SETTLE_CYCLES; leaving when it reads
               // 1 gives exactly SETTLE_CYCLES cycles in this state.
               settle_cnt <= settle_cnt - 8'd1;
               if (settle_cnt <= 8'd1) begin
                  state <= S_CHECK;
               end
            end

            S_CHECK: begin
               fail_mask <= mask_upd;
`ifdef QUAD_OR_ABORT_ON_FAIL_EN
               if (mism != 4'd0) begin
                  fail_vec <= vec_idx;
                  state    <= S_DONE;
               end else
`endif
               if (vec_idx != 2'd3) begin
                  vec_idx <= next_idx;
                  a_out   <= a_map;
                  b_out   <= b_map;
                  state   <= S_APPLY;
               end else if (loop_cnt < LOOP_LAST) begin
                  loop_cnt <= loop_cnt + 4'd1;
                  vec_idx  <= next_idx;
                  a_out    <= a_map;
                  b_out    <= b_map;
                  state    <= S_APPLY;
               end else begin
                  state <= S_DONE;
               end
            end

            S_DONE: begin
               // fail_mask already holds the result of the final CHECK.
               done  <= 1'b1;
               busy  <= 1'b0;
               pass  <= (fail_mask == 4'd0);
               a_out <= 4'd0;
               b_out <= 4'd0;
               state <= S_IDLE;
            end

            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_quad_or_self_test_ctrl.sv
// ---------------------------------------------------------------------------
// tb_quad_or_self_test_ctrl
//
// Directed bench for quad_or_self_test_ctrl. Two instances share clock and
// reset: dut_a (SETTLE_CYCLES=2, LOOPS=1) and dut_b (SETTLE_CYCLES=0,
// LOOPS=3). Each drives a behavioural OR gate whose outputs can be faulted:
//   mode 0 fault-free, 1 Y3 stuck-at-0, 2 Y1/Y2 wired-OR short,
//   3 Y4 stuck-at-1.
// ---------------------------------------------------------------------------
module tb_quad_or_self_test_ctrl;

   logic       clk;
   logic       reset;
   logic       start_a, start_b;
   logic       busy_a, busy_b, done_a, done_b, pass_a, pass_b;
   logic [3:0] a_a, b_a, a_b, b_b, y_a, y_b, fm_a, fm_b;
   logic [1:0] vi_a, vi_b;
`ifdef QUAD_OR_ABORT_ON_FAIL_EN
   logic [1:0] fv_a, fv_b;
`endif
   int         mode_a, mode_b;
   int         sel;
   int         checks;
   int         errors;

   // muxed view of the instance under test
   logic       busy_m, done_m, pass_m;
   logic [3:0] a_m, b_m, fm_m;
   logic [1:0] vi_m;

   quad_or_self_test_ctrl #(.SETTLE_CYCLES(2), .LOOPS(1)) dut_a (
      .clk(clk), .reset(reset), .start(start_a), .busy(busy_a), .done(done_a),
      .pass(pass_a), .a_out(a_a), .b_out(b_a), .y_in(y_a), .fail_mask(fm_a),
`ifdef QUAD_OR_ABORT_ON_FAIL_EN
      .fail_vec(fv_a),
`endif
      .vec_idx(vi_a)
   );

   quad_or_self_test_ctrl #(.SETTLE_CYCLES(0), .LOOPS(3)) dut_b (
      .clk(clk), .reset(reset), .start(start_b), .busy(busy_b), .done(done_b),
      .pass(pass_b), .a_out(a_b), .b_out(b_b), .y_in(y_b), .fail_mask(fm_b),
`ifdef QUAD_OR_ABORT_ON_FAIL_EN
      .fail_vec(fv_b),
`endif
      .vec_idx(vi_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [3:0] gate(input logic [3:0] a, input logic [3:0] b,
                                       input int mode);
      logic [3:0] y;
      logic       t;
      y = a | b;
      case (mode)
         1: y[2] = 1'b0;
         2: begin t = y[0] | y[1]; y[0] = t; y[1] = t; end
         3: y[3] = 1'b1;
         default: ;
      endcase
      return y;
   endfunction

   always_comb y_a = gate(a_a, b_a, mode_a);
   always_comb y_b = gate(a_b, b_b, mode_b);

   always_comb begin
      busy_m = busy_a; done_m = done_a; pass_m = pass_a;
      a_m = a_a; b_m = b_a; fm_m = fm_a; vi_m = vi_a;
      if (sel != 0) begin
         busy_m = busy_b; done_m = done_b; pass_m = pass_b;
         a_m = a_b; b_m = b_b; fm_m = fm_b; vi_m = vi_b;
      end
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Pulses start, then counts edges after the accept edge until done.
   // seq_chk enables the vector/sequence checks for a full SETTLE=2 run;
   // ignore_at (>0) pulses start again while the run is busy.
   task automatic run(input string name, input bit seq_chk, input int ignore_at,
                      output int lat);
      @(negedge clk);
      if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0; start_b = 1'b0;
      lat = -1;
      for (int n = 1; n <= 200; n++) begin
         @(posedge clk); #1;
         if (n == 1) begin
            check({name, "_busy_rise"}, 32'(busy_m), 32'd1);
            check({name, "_pass_clr"}, 32'(pass_m), 32'd0);
         end
         if (seq_chk) begin
            if (n == 1) begin
               check({name, "_a_v0"}, 32'(a_m), 32'hC);
               check({name, "_b_v0"}, 32'(b_m), 32'hA);
            end
            if (n == 5) begin
               check({name, "_a_v1"}, 32'(a_m), 32'h6);
               check({name, "_b_v1"}, 32'(b_m), 32'h5);
            end
            if (n == 1 || n == 5 || n == 9 || n == 13)
               check({name, "_vec_idx"}, 32'(vi_m), 32'((n - 1) / 4));
         end
         if (ignore_at > 0 && n == ignore_at) start_b = 1'b1;
         if (ignore_at > 0 && n == ignore_at + 1) start_b = 1'b0;
         if (done_m) begin
            lat = n;
            break;
         end
      end
      start_b = 1'b0;
      $display("run %s: latency %0d pass %0b fail_mask %b", name, lat, pass_m, fm_m);
      check({name, "_busy_at_done"}, 32'(busy_m), 32'd0);
      @(posedge clk); #1;
      check({name, "_done_pulse"}, 32'(done_m), 32'd0);
      check({name, "_a_idle"}, 32'(a_m), 32'd0);
      check({name, "_b_idle"}, 32'(b_m), 32'd0);
   endtask

   int lat;
   int done_cnt;

   initial begin
      checks = 0; errors = 0;
      reset = 1'b1; start_a = 1'b0; start_b = 1'b0;
      mode_a = 0; mode_b = 0; sel = 0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", 32'(busy_a), 32'd0);
      check("rst_done", 32'(done_a), 32'd0);
      check("rst_pass", 32'(pass_a), 32'd0);
      check("rst_ab", 32'({a_a, b_a}), 32'd0);
      check("rst_mask", 32'(fm_a), 32'd0);
      check("rst_vec", 32'(vi_a), 32'd0);
      @(negedge clk); reset = 1'b0;

      // fault-free gate
      run("clean", 1'b1, 0, lat);
      check("clean_lat", 32'(lat), 32'd17);
      check("clean_pass", 32'(pass_a), 32'd1);
      check("clean_mask", 32'(fm_a), 32'd0);
      repeat (3) @(posedge clk);
      #1 check("clean_pass_held", 32'(pass_a), 32'd1);

      // Y3 stuck-at-0: channel 3 sees v=2 first (expects 1)
      mode_a = 1;
`ifdef QUAD_OR_ABORT_ON_FAIL_EN
      run("y3_sa0", 1'b0, 0, lat);
      check("y3_sa0_lat", 32'(lat), 32'd5);
      check("y3_sa0_fvec", 32'(fv_a), 32'd0);
`else
      run("y3_sa0", 1'b1, 0, lat);
      check("y3_sa0_lat", 32'(lat), 32'd17);
`endif
      check("y3_sa0_mask", 32'(fm_a), 32'h4);
      check("y3_sa0_pass", 32'(pass_a), 32'd0);

      // Y1/Y2 short: vector 0 gives ch1 0 vs ch2 1, vector 3 gives ch1 1 vs ch2 0
      mode_a = 2;
`ifdef QUAD_OR_ABORT_ON_FAIL_EN
      run("short12", 1'b0, 0, lat);
      check("short12_lat", 32'(lat), 32'd5);
      check("short12_mask", 32'(fm_a), 32'h1);
      check("short12_fvec", 32'(fv_a), 32'd0);
`else
      run("short12", 1'b1, 0, lat);
      check("short12_lat", 32'(lat), 32'd17);
      check("short12_mask", 32'(fm_a), 32'h3);
`endif
      check("short12_pass", 32'(pass_a), 32'd0);

      // Y4 stuck-at-1: first failure at vector 1 (channel 4 v=0)
      mode_a = 3;
`ifdef QUAD_OR_ABORT_ON_FAIL_EN
      run("y4_sa1", 1'b0, 0, lat);
      check("y4_sa1_lat", 32'(lat), 32'd9);
      check("y4_sa1_fvec", 32'(fv_a), 32'd1);
`else
      run("y4_sa1", 1'b1, 0, lat);
      check("y4_sa1_lat", 32'(lat), 32'd17);
`endif
      check("y4_sa1_mask", 32'(fm_a), 32'h8);
      check("y4_sa1_pass", 32'(pass_a), 32'd0);

      // LOOPS=3, SETTLE_CYCLES=0, extra start at cycle 10 must be ignored
      mode_a = 0;
      sel = 1;
      run("loops3", 1'b0, 10, lat);
      check("loops3_lat", 32'(lat), 32'd25);
      check("loops3_pass", 32'(pass_b), 32'd1);
      done_cnt = 0;
      for (int n = 0; n < 10; n++) begin
         @(posedge clk); #1;
         if (done_b || busy_b) done_cnt++;
      end
      check("loops3_no_rerun", 32'(done_cnt), 32'd0);
      sel = 0;

      // reset during SETTLE of vector 2 (state SETTLE after edge 10)
      @(negedge clk); start_a = 1'b1;
      @(posedge clk); #1 start_a = 1'b0;
      repeat (10) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check("abort_vec_before", 32'(vi_a), 32'd0);
      check("abort_busy", 32'(busy_a), 32'd0);
      check("abort_ab", 32'({a_a, b_a}), 32'd0);
      check("abort_pass", 32'(pass_a), 32'd0);
      check("abort_mask", 32'(fm_a), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk); reset = 1'b0;
      done_cnt = 0;
      for (int n = 0; n < 20; n++) begin
         @(posedge clk); #1;
         if (done_a) done_cnt++;
      end
      check("abort_no_done", 32'(done_cnt), 32'd0);
      $display("run reset_abort: done pulses after reset %0d", done_cnt);

      run("after_rst", 1'b1, 0, lat);
      check("after_rst_lat", 32'(lat), 32'd17);
      check("after_rst_pass", 32'(pass_a), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/quad_or_self_test_ctrl.md
Name: quad_or_self_test_ctrl

Overview:
- Built-in self-test sequencer for one quad 2-input OR gate package in the digital clock IP library.
- Drives the a/b inputs of all four channels through every input combination and waits a settle window that covers the gate propagation DELAY.
- Samples the four Y outputs, compares each against a|b, and reports per-channel faults with a start/busy/done handshake.
- Sits between the board-level test/boot logic and the gate instance.

Parameters:
- SETTLE_CYCLES, 2, clock cycles held in SETTLE after each vector is applied; must exceed gate DELAY in clocks; legal range 0..255.
- LOOPS, 1, number of full 4-vector passes per test run; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request a test run; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until the cycle before done.
- done  out  1  one-cycle pulse at end of run.
- pass  out  1  result of last run, 1 = no channel failed; held until the next accepted start.
- a_out  out  4  channel a inputs to gate; bit k = channel k+1.
- b_out  out  4  channel b inputs to gate.
- y_in  in  4  gate outputs Y1..Y4; bit k = Yk+1.
- fail_mask  out  4  sticky per-channel mismatch flags.
- vec_idx  out  2  current vector index, for debug.

Behaviour:
- Reset (async, any state): FSM goes to IDLE; busy=0, done=0, pass=0, a_out=0, b_out=0, fail_mask=0, vec_idx=0; pass counter and settle counter cleared.
- FSM states: IDLE, APPLY, SETTLE, CHECK, DONE.
- IDLE, start=1 at a clock edge:
  - clear fail_mask, pass, vec_idx and pass counter;
  - go to APPLY; busy=1 from the next cycle.
- Vector mapping: channel k (0..3) receives v=(vec_idx+k) mod 4, with {a,b}=v[1:0].
  - The stagger guarantees neighbouring channels never see identical inputs; this exposes inter-channel shorts.
- APPLY (1 cycle):
  - a_out/b_out are registered with the mapped vector;
  - settle counter loaded with SETTLE_CYCLES;
  - next state is SETTLE if SETTLE_CYCLES>0, else CHECK.
- SETTLE: counter decrements each cycle; leave for CHECK in the cycle it reaches 1 (exactly SETTLE_CYCLES cycles spent).
- CHECK (1 cycle):
  - for each k, fail_mask[k] |= y_in[k] ^ (a_out[k]|b_out[k]);
  - if vec_idx<3: vec_idx++, go to APPLY;
  - else if pass counter < LOOPS-1: pass counter++, vec_idx=0, go to APPLY;
  - else go to DONE.
- DONE (1 cycle): done=1, busy=0, pass=(fail_mask==0) computed including the final CHECK; a_out/b_out return to 0; next state IDLE.
- Cycles per vector = SETTLE_CYCLES+2.
- Latency from the start-accept edge to the done pulse = LOOPS*4*(SETTLE_CYCLES+2)+1 cycles.
- start while busy or in DONE is ignored; it is not queued.
- a_out/b_out are stable for the whole APPLY..CHECK span of a vector; they are 0 in IDLE.
- fail_mask bits never clear during a run, only on start accept or reset.
- Reset asserted mid-run aborts the run: no done pulse, and pass=0.

Optional Feature:
- Macro: QUAD_OR_ABORT_ON_FAIL_EN.
- Defined:
  - adds output fail_vec (2 bits, reset 0), captured with vec_idx at the first CHECK that sets any fail_mask bit;
  - the FSM goes from that CHECK straight to DONE with pass=0, skipping the remaining vectors and loops.
- Undefined:
  - fail_vec port absent;
  - the run always completes all LOOPS*4 vectors; fail_mask accumulates every failing channel.

Test Plan:
- Fault-free gate model (Y=a|b, 10 ns delay), SETTLE_CYCLES=2, LOOPS=1, 10 ns clock, pulse start:
  - busy rises the next cycle;
  - vec_idx steps 0,1,2,3;
  - done pulses 17 cycles after the accept edge;
  - pass=1, fail_mask=0000.
- Channel 3 output stuck-at-0:
  - after done, fail_mask=0100 and pass=0;
  - channels 1, 2, 4 are unaffected.
- Y1 shorted to Y2:
  - stagger produces a mismatch; fail_mask has bit0 and/or bit1 set; pass=0.
- LOOPS=3, SETTLE_CYCLES=0:
  - done at 3*4*2+1=25 cycles;
  - start pulsed at cycle 10 is ignored, with no second run;
  - a_out/b_out return to 0 after DONE.
- Reset asserted during SETTLE of vector 2:
  - all outputs are 0 immediately, asynchronously, with no done pulse;
  - a new start runs a full test normally.
- QUAD_OR_ABORT_ON_FAIL_EN defined, channel 4 stuck-at-1, SETTLE_CYCLES=2:
  - first CHECK (vector 0, channel 4 v=3, expected 1) passes;
  - vector 1 (channel 4 v=0, expected 0) fails: fail_vec=1, fail_mask=1000;
  - done at cycle 9, pass=0.
